// File: rtl/hex_scan_sb_ctrl.sv
// Bus-mapped controller for a multiplexed bank of 7-segment digits with built-in scan timing.
// Optional blink support is compiled in with `define HEX_SCAN_BLINK_EN.
module hex_scan_sb_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic              req_i,
  input  logic              write_enable_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  output logic [6:0]        hex_led_o,
  output logic [DIGITS-1:0] hex_sel_o
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW   = $clog2(SCAN_DIV);

  logic [3:0]        r_digit [DIGITS];
  logic [DIGITS-1:0] r_enable;
  logic [PW-1:0]     r_presc;
  logic [IDXW-1:0]   r_idx;
  logic [DIGITS-1:0] r_sel;
  logic [6:0]        r_led;
  logic [31:0]       r_rdata;

  logic              w_wr, w_rd, w_srst, w_rst_any;
  logic              w_dig_region, w_en_hit, w_bl_hit, w_srst_hit, w_mask_ok;
  logic              w_scan_wrap;
  logic [IDXW-1:0]   w_idx_next;
  logic [3:0]        w_cur_digit;
  logic              w_cur_en, w_cur_vis;
  logic [6:0]        w_seg;
  logic [31:0]       w_rdata;

  assign w_wr         = req_i & write_enable_i;
  assign w_rd         = req_i & ~write_enable_i;
  assign w_dig_region = (addr_i[31:6] == 26'd0) && (addr_i[1:0] == 2'd0) &&
                        (32'(addr_i[5:2]) < 32'(DIGITS));
  assign w_en_hit     = (addr_i == 32'h40);
  assign w_bl_hit     = (addr_i == 32'h44);
  assign w_srst_hit   = (addr_i == 32'h48);
  assign w_mask_ok    = ((write_data_i >> DIGITS) == 32'd0);
  // Soft reset clears everything a hard reset does except the read data register.
  assign w_srst       = w_wr & w_srst_hit & (write_data_i == 32'd1);
  assign w_rst_any    = rst_i | w_srst;

  assign w_scan_wrap = (r_presc == PW'(SCAN_DIV - 1));
  assign w_idx_next  = (r_idx == IDXW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;

`ifdef HEX_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [DIGITS-1:0] r_blink;
  logic [BW-1:0]     r_bcnt;
  logic              r_phase_on;

  always_ff @(posedge clk_i) begin
    if (w_rst_any) begin
      r_blink    <= '0;
      r_bcnt     <= '0;
      r_phase_on <= 1'b1;
    end else begin
      if (w_wr && w_bl_hit && w_mask_ok)
        r_blink <= write_data_i[DIGITS-1:0];
      if (r_bcnt == BW'(BLINK_DIV - 1)) begin
        r_bcnt     <= '0;
        r_phase_on <= ~r_phase_on;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_blink_div;
  assign w_unused_blink_div = (BLINK_DIV > 1) & w_bl_hit;
`endif

  always_ff @(posedge clk_i) begin
    if (w_rst_any) begin
      for (int i = 0; i < DIGITS; i++) r_digit[i] <= 4'd0;
      r_enable <= '0;
      r_presc  <= '0;
      r_idx    <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (w_wr && w_dig_region && addr_i[5:2] == 4'(i) && write_data_i < 32'd16)
          r_digit[i] <= write_data_i[3:0];
      if (w_wr && w_en_hit && w_mask_ok)
        r_enable <= write_data_i[DIGITS-1:0];
      if (w_scan_wrap) begin
        r_presc <= '0;
        r_idx   <= w_idx_next;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  always_comb begin
    w_cur_digit = 4'd0;
    w_cur_en    = 1'b0;
    w_cur_vis   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_cur_digit = r_digit[i];
        w_cur_en    = r_enable[i];
`ifdef HEX_SCAN_BLINK_EN
        w_cur_vis   = ~r_blink[i] | r_phase_on;
`endif
      end
    end
  end

  always_comb begin
    w_seg = 7'h00;
    case (w_cur_digit)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    for (int i = 0; i < DIGITS; i++)
      if (w_dig_region && addr_i[5:2] == 4'(i))
        w_rdata = {28'd0, r_digit[i]};
    if (w_en_hit)
      w_rdata = 32'(r_enable);
`ifdef HEX_SCAN_BLINK_EN
    if (w_bl_hit)
      w_rdata = 32'(r_blink);
`endif
  end

  // Outputs lag the scan index by one cycle; a dark slot always blanks the segments.
  always_ff @(posedge clk_i) begin
    if (w_rst_any) begin
      r_sel <= '1;
      r_led <= 7'h7F;
    end else if (w_cur_en && w_cur_vis) begin
      r_sel <= ~(DIGITS'(1) << r_idx);
      r_led <= ~w_seg;
    end else begin
      r_sel <= '1;
      r_led <= 7'h7F;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_rdata <= 32'd0;
    else if (w_rd)
      r_rdata <= w_rdata;
  end

  assign read_data_o = r_rdata;
  assign hex_led_o   = r_led;
  assign hex_sel_o   = r_sel;

endmodule

// File: tb/tb_hex_scan_sb_ctrl.sv
// Directed bench for hex_scan_sb_ctrl (5 digits, fast scan/blink) with a per-cycle scoreboard.
module tb_hex_scan_sb_ctrl;

  localparam int ND = 5;
  localparam int SD = 4;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   wdata = 32'd0;
  logic [31:0]   rdata;
  logic [6:0]    led;
  logic [ND-1:0] sel;

  hex_scan_sb_ctrl #(.DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .req_i(req), .write_enable_i(we),
    .write_data_i(wdata), .read_data_o(rdata), .hex_led_o(led), .hex_sel_o(sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] sel;
    logic [6:0]    led;
    logic [31:0]   rd;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  logic [6:0]    seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_en = '0;
  logic [ND-1:0] m_bl = '0;
  int            m_n = 0;
  logic [ND-1:0] m_sel = '1;
  logic [6:0]    m_led = 7'h7F;
  logic [31:0]   m_rd = 32'd0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'h40 && a[1:0] == 2'd0 && int'(a[5:2]) < ND) return {28'd0, m_dig[a[5:2]]};
    if (a == 32'h40) return 32'(m_en);
`ifdef HEX_SCAN_BLINK_EN
    if (a == 32'h44) return 32'(m_bl);
`endif
    return 32'd0;
  endfunction

  // Advance the reference model by one clock edge, then compare after the DUT's edge.
  task automatic step();
    exp_t e;
    int   idx;
    bit   vis;
    if (rst || (req && we && addr == 32'h48 && wdata == 32'd1)) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;
      m_en = '0; m_bl = '0; m_n = 0;
      m_sel = '1; m_led = 7'h7F;
      if (rst) m_rd = 32'd0;
    end else begin
      idx = (m_n / SD) % ND;
      vis = 1'b1;
`ifdef HEX_SCAN_BLINK_EN
      vis = !m_bl[idx] || (((m_n / BD) % 2) == 0);
`endif
      if (m_en[idx] && vis) begin
        m_sel = ~(ND'(1) << idx);
        m_led = ~seg_tab[m_dig[idx]];
      end else begin
        m_sel = '1;
        m_led = 7'h7F;
      end
      if (req && !we) m_rd = model_read(addr);
      if (req && we) begin
        if (addr < 32'h40 && addr[1:0] == 2'd0 && int'(addr[5:2]) < ND && wdata < 32'd16)
          m_dig[addr[5:2]] = wdata[3:0];
        if (addr == 32'h40 && wdata < (32'd1 << ND)) m_en = wdata[ND-1:0];
`ifdef HEX_SCAN_BLINK_EN
        if (addr == 32'h44 && wdata < (32'd1 << ND)) m_bl = wdata[ND-1:0];
`endif
      end
      m_n++;
    end
    e.sel = m_sel; e.led = m_led; e.rd = m_rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_assert++;
    assert (sel === e.sel) else begin
      n_fail++; $error("FAIL sel t=%0t observed %h expected %h", $time, sel, e.sel);
    end
    n_assert++;
    assert (led === e.led) else begin
      n_fail++; $error("FAIL led t=%0t observed %h expected %h", $time, led, e.led);
    end
    n_assert++;
    assert (rdata === e.rd) else begin
      n_fail++; $error("FAIL rdata t=%0t observed %h expected %h", $time, rdata, e.rd);
    end
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    req = 1'b1; we = 1'b0; addr = a; wdata = 32'hDEAD_BEEF;
    step();
    req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;
    // Hard reset, then confirm ENABLE reads back as zero.
    rst = 1'b1; step(); rst = 1'b0;
    rd(32'h40);
    idle(2);

    // Single lit digit in slot 3 with value A.
    wr(32'h0C, 32'hA);
    wr(32'h40, 32'h08);
    idle(2 * ND * SD);

    // Out-of-range values are rejected; boundary values are accepted.
    wr(32'h00, 32'h10);
    wr(32'h40, 32'h20);
    rd(32'h00);
    rd(32'h40);
    wr(32'h04, 32'hF);
    wr(32'h40, 32'h1F);
    rd(32'h04);
    rd(32'h40);

    // Offsets past the last digit, unaligned and unmapped accesses.
    wr(32'h14, 32'h5);
    rd(32'h14);
    wr(32'h0D, 32'h3);
    rd(32'h0C);
    rd(32'h100);
    rd(32'h48);

    // All digits lit with distinct values, then a second set of values.
    for (int i = 0; i < ND; i++) wr(32'(4 * i), 32'(i + 9));
    idle(ND * SD + 3);
    for (int i = 0; i < ND; i++) wr(32'(4 * i), 32'((i * 3 + 2) % 16));
    idle(ND * SD + 3);

    // Soft reset: a non-1 value is a no-op, 1 clears state but keeps read data.
    rd(32'h0C);
    idle(3);
    wr(32'h48, 32'h2);
    idle(2);
    wr(32'h48, 32'h1);
    idle(3);
    rd(32'h0C);
    rd(32'h40);

    // Hard reset concurrent with a write: reset wins.
    wr(32'h40, 32'h1F);
    wr(32'h08, 32'h7);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h3; rst = 1'b1;
    step();
    rst = 1'b0; req = 1'b0; we = 1'b0;
    rd(32'h40);
    rd(32'h08);

    // Blink on digit 0.
    wr(32'h00, 32'h5);
    wr(32'h40, 32'h01);
    wr(32'h44, 32'h01);
    rd(32'h44);
    idle(4 * BD + ND * SD);
    wr(32'h44, 32'h20);
    rd(32'h44);
    idle(2 * ND * SD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
